fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_timeout_ctr.sv | 33 +++
 rtl/fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/control definitions: FSM state encoding, NOP word and the
// major opcode constants used by both the fetch unit and the control unit.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ready);

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts REQ cycles without a memory response; flags expiry on the last
// allowed cycle so the fetch FSM can drop the request at the same edge.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;
  logic          tick;

  assign tick    = active && !mem_ready;
  assign expired = tick && (count_reg == LAST_COUNT);

  // Held at zero outside REQ, so every entry into REQ starts a fresh count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (!active) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/DONE/ERR sequencer loading the IR from memory.
// Optional request timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          irwrite,
  input  logic          pcwrite,
  input  logic [31:0]   pc_next,
  fetch_unit_if.master  mem,
  output logic [31:0]   pc,
  output logic [31:0]   old_pc,
  output logic [31:0]   instr,
  output logic [6:0]    opcode,
  output logic [2:0]    funct3,
  output logic          func7_bit5,
  output logic          fetch_valid,
  output logic          fetch_err
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  old_pc_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  mem_addr_reg;
  logic         mem_req_reg;
  logic         fetch_valid_reg;
  logic         fetch_err_reg;
  logic         timeout_expired;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .active    (state_reg == ST_REQ),
    .mem_ready (mem.mem_ready),
    .expired   (timeout_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_expired    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      pc_reg          <= RESET_PC;
      old_pc_reg      <= RESET_PC;
      instr_reg       <= NOP_INSTR;
      mem_addr_reg    <= RESET_PC;
      mem_req_reg     <= 1'b0;
      fetch_valid_reg <= 1'b0;
      fetch_err_reg   <= 1'b0;
    end else begin
      fetch_valid_reg <= 1'b0;
      // PC updates are independent of the fetch in flight; only ERR freezes them.
      if (pcwrite && state_reg != ST_ERR) begin
        pc_reg <= pc_next;
      end
      case (state_reg)
        ST_IDLE: begin
          if (irwrite) begin
            if (is_word_aligned(pc_reg[1:0])) begin
              state_reg    <= ST_REQ;
              mem_addr_reg <= pc_reg;
              mem_req_reg  <= 1'b1;
            end else begin
              state_reg     <= ST_ERR;
              fetch_err_reg <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_ready) begin
            state_reg       <= ST_DONE;
            instr_reg       <= mem.mem_rdata;
            old_pc_reg      <= mem_addr_reg;
            mem_req_reg     <= 1'b0;
            fetch_valid_reg <= 1'b1;
          end else if (timeout_expired) begin
            state_reg     <= ST_ERR;
            mem_req_reg   <= 1'b0;
            fetch_err_reg <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg     <= ST_ERR;
          mem_req_reg   <= 1'b0;
          fetch_err_reg <= 1'b1;
        end
      endcase
    end
  end

  assign mem.mem_req  = mem_req_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign pc           = pc_reg;
  assign old_pc       = old_pc_reg;
  assign instr        = instr_reg;
  assign fetch_valid  = fetch_valid_reg;
  assign fetch_err    = fetch_err_reg;

  assign opcode     = instr_reg[6:0];
  assign funct3     = instr_reg[14:12];
  assign func7_bit5 = instr_reg[30];

endmodule
